// File: rtl/fp32_to_fixed_if.sv
// rtl/fp32_to_fixed_if.sv - handshake/data bundle for the fp32_to_fixed converter
//
// Purpose: groups the input stream (valid_in/ready_out/a_in) and the result
// stream (valid_out/ready_in/fixed_out + flags) of fp32_to_fixed.
// Ports (signals):
//   valid_in     1   a_in is valid this cycle
//   ready_out    1   converter accepts a_in this cycle
//   a_in         32  binary32 operand {sign, exp[7:0], frac[22:0]}
//   valid_out    1   fixed_out/flags valid
//   ready_in     1   downstream accepts the result
//   fixed_out    32  signed fixed-point result
//   overflow_out 1   result saturated (range exceeded or +/-inf)
//   inexact_out  1   nonzero bits discarded by truncation
//   invalid_out  1   input was NaN
// Modports: slave = converter side, master = producer/consumer side.
interface fp32_to_fixed_if;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] a_in;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] fixed_out;
  logic        overflow_out;
  logic        inexact_out;
  logic        invalid_out;

  modport slave (
    input  valid_in,
    input  a_in,
    input  ready_in,
    output ready_out,
    output valid_out,
    output fixed_out,
    output overflow_out,
    output inexact_out,
    output invalid_out
  );

  modport master (
    output valid_in,
    output a_in,
    output ready_in,
    input  ready_out,
    input  valid_out,
    input  fixed_out,
    input  overflow_out,
    input  inexact_out,
    input  invalid_out
  );
endinterface

// File: rtl/fp32_to_fixed.sv
// rtl/fp32_to_fixed.sv - 3-stage binary32 to signed Q(31-FRAC_BITS).FRAC_BITS converter
//
// Purpose: converts IEEE-754 binary32 operands to 32-bit two's-complement fixed
// point, truncating toward zero and saturating out-of-range values. Flags
// (overflow/inexact/invalid) are one-hot or all zero and travel with the result.
// Stages: 1 unpack/classify, 2 align (shift + sticky), 3 saturate/sign.
// Ports:
//   clk_in    1   clock, rising edge
//   rst_n_in  1   asynchronous active-low reset
//   bus       fp32_to_fixed_if.slave (input and result streams, see interface)
// Parameters:
//   FRAC_BITS number of fractional result bits, 0..30
module fp32_to_fixed #(
  parameter int FRAC_BITS = 16
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  fp32_to_fixed_if.slave  bus
);

  // One global enable: the whole pipe advances only when the output register
  // is empty or being drained. Bubbles are kept, never collapsed.
  logic en;
  assign en            = !bus.valid_out || bus.ready_in;
  assign bus.ready_out = en;

  // ---------------------------------------------------------------- stage 1
  logic [7:0]        a_exp;
  logic [22:0]       a_frac;
  logic              a_exp_zero;
  logic              a_exp_max;
  logic              a_frac_nz;
  logic signed [9:0] a_sh;

  assign a_exp      = bus.a_in[30:23];
  assign a_frac     = bus.a_in[22:0];
  assign a_exp_zero = (a_exp == 8'd0);
  assign a_exp_max  = (a_exp == 8'hFF);
  assign a_frac_nz  = |a_frac;
  // Left-shift amount that places the 24-bit mantissa's LSB at the fixed-point
  // LSB: value = m * 2^(e-150), result LSB weight = 2^-FRAC_BITS.
  // Range -150..135 fits a signed 10-bit value.
  assign a_sh = $signed({2'b00, a_exp}) - 10'sd150 + 10'(FRAC_BITS);

  logic              s1_valid;
  logic              s1_sign;
  logic signed [9:0] s1_sh;
  logic [23:0]       s1_mant;
  logic              s1_normal;
  logic              s1_denorm;
  logic              s1_inf;
  logic              s1_nan;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_sh     <= '0;
      s1_mant   <= '0;
      s1_normal <= 1'b0;
      s1_denorm <= 1'b0;
      s1_inf    <= 1'b0;
      s1_nan    <= 1'b0;
    end else if (en) begin
      s1_valid  <= bus.valid_in;
      s1_sign   <= bus.a_in[31];
      s1_sh     <= a_sh;
      s1_mant   <= {1'b1, a_frac};
      s1_normal <= !a_exp_zero && !a_exp_max;
      s1_denorm <= a_exp_zero && a_frac_nz;
      s1_inf    <= a_exp_max && !a_frac_nz;
      s1_nan    <= a_exp_max && a_frac_nz;
    end
  end

  // ---------------------------------------------------------------- stage 2
  // Left path is 64 bits wide so any bit pushed past bit 31 is still seen.
  logic [63:0] up_mag;
  logic        up_big;
  logic [4:0]  dn_sh;
  logic [23:0] dn_mag;
  logic        dn_sticky;

  assign up_mag = {40'd0, s1_mant} << $unsigned(s1_sh);
  // The 64-bit shift wraps to zero for very large exponents; sh>8 alone
  // already means the implicit one lands above bit 31.
  assign up_big = (s1_sh > 10'sd8) || (|up_mag[63:32]);

  // Only meaningful for -24 <= sh < 0, so a 5-bit right-shift amount suffices.
  assign dn_sh     = 5'(-s1_sh);
  assign dn_mag    = s1_mant >> dn_sh;
  assign dn_sticky = |(s1_mant & ~({24{1'b1}} << dn_sh));

  logic [31:0] mag_n;
  logic        big_n;
  logic        sticky_n;

  always_comb begin
    mag_n    = 32'd0;
    big_n    = 1'b0;
    sticky_n = 1'b0;
    if (s1_normal) begin
      if (!s1_sh[9]) begin
        mag_n = up_mag[31:0];
        big_n = up_big;
      end else if (s1_sh >= -10'sd24) begin
        mag_n    = {8'd0, dn_mag};
        sticky_n = dn_sticky;
      end else begin
        // Entire mantissa (including the implicit one) falls off the end.
        sticky_n = 1'b1;
      end
    end else if (s1_denorm) begin
      // Denormals are far below 2^-30, so they always truncate to zero.
      sticky_n = 1'b1;
    end
  end

  logic        s2_valid;
  logic        s2_sign;
  logic [31:0] s2_mag;
  logic        s2_big;
  logic        s2_sticky;
  logic        s2_inf;
  logic        s2_nan;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_mag    <= '0;
      s2_big    <= 1'b0;
      s2_sticky <= 1'b0;
      s2_inf    <= 1'b0;
      s2_nan    <= 1'b0;
    end else if (en) begin
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_mag    <= mag_n;
      s2_big    <= big_n;
      s2_sticky <= sticky_n;
      s2_inf    <= s1_inf;
      s2_nan    <= s1_nan;
    end
  end

  // ---------------------------------------------------------------- stage 3
  // Positive limit is 0x7FFFFFFF; negative limit is 0x80000000, which is
  // itself representable, so only magnitudes strictly above it saturate.
  logic pos_sat;
  logic neg_sat;

  assign pos_sat = !s2_sign && s2_mag[31];
  assign neg_sat = s2_sign && s2_mag[31] && (|s2_mag[30:0]);

  logic [31:0] fixed_n;
  logic        overflow_n;
  logic        inexact_n;
  logic        invalid_n;

  always_comb begin
    fixed_n    = 32'd0;
    overflow_n = 1'b0;
    inexact_n  = 1'b0;
    invalid_n  = 1'b0;
    // Empty slots load zeros so flags never linger without valid_out.
    if (s2_valid) begin
      if (s2_nan) begin
        invalid_n = 1'b1;
      end else if (s2_inf || s2_big || pos_sat || neg_sat) begin
        fixed_n    = s2_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        overflow_n = 1'b1;
      end else begin
        fixed_n   = s2_sign ? (32'd0 - s2_mag) : s2_mag;
        inexact_n = s2_sticky;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bus.valid_out    <= 1'b0;
      bus.fixed_out    <= '0;
      bus.overflow_out <= 1'b0;
      bus.inexact_out  <= 1'b0;
      bus.invalid_out  <= 1'b0;
    end else if (en) begin
      bus.valid_out    <= s2_valid;
      bus.fixed_out    <= fixed_n;
      bus.overflow_out <= overflow_n;
      bus.inexact_out  <= inexact_n;
      bus.invalid_out  <= invalid_n;
    end
  end

endmodule

// File: tb/tb_fp32_to_fixed.sv
// tb/tb_fp32_to_fixed.sv - directed self-checking bench for fp32_to_fixed
module tb_fp32_to_fixed;

  logic clk = 1'b0;
  logic rst_n16;
  logic rst_n0;
  int   total  = 0;
  int   passed = 0;

  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_OV   = 3'b100;
  localparam logic [2:0] F_INX  = 3'b010;
  localparam logic [2:0] F_INV  = 3'b001;

  fp32_to_fixed_if if16 ();
  fp32_to_fixed_if if0 ();

  fp32_to_fixed #(.FRAC_BITS(16)) dut16 (
    .clk_in   (clk),
    .rst_n_in (rst_n16),
    .bus      (if16.slave)
  );

  fp32_to_fixed #(.FRAC_BITS(0)) dut0 (
    .clk_in   (clk),
    .rst_n_in (rst_n0),
    .bus      (if0.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic vo(input bit sel);
    return sel ? if0.valid_out : if16.valid_out;
  endfunction

  function automatic logic [31:0] fo(input bit sel);
    return sel ? if0.fixed_out : if16.fixed_out;
  endfunction

  function automatic logic [2:0] flo(input bit sel);
    return sel ? {if0.overflow_out, if0.inexact_out, if0.invalid_out}
               : {if16.overflow_out, if16.inexact_out, if16.invalid_out};
  endfunction

  // Send one operand into an empty pipe, check latency, value and flags.
  task automatic run_one(input bit sel, input string tag, input logic [31:0] a,
                         input logic [31:0] ef, input logic [2:0] efl);
    int n;
    if (sel) begin
      if0.a_in = a; if0.valid_in = 1'b1;
    end else begin
      if16.a_in = a; if16.valid_in = 1'b1;
    end
    step();
    if (sel) if0.valid_in = 1'b0;
    else     if16.valid_in = 1'b0;
    n = 1;
    while (!vo(sel) && n < 10) begin
      step();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd3);
    check({tag, "_val"}, fo(sel), ef);
    check({tag, "_flg"}, 32'(flo(sel)), 32'(efl));
  endtask

  logic [31:0] svec [8];
  logic [31:0] sexp [8];
  int          idx;
  int          got;
  bit          hold;
  bit          acc;
  bit          ret;
  logic [31:0] held;

  initial begin
    svec = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    for (int k = 0; k < 8; k++) sexp[k] = 32'(k + 1) << 16;

    if16.valid_in = 1'b0; if16.a_in = '0; if16.ready_in = 1'b1;
    if0.valid_in  = 1'b0; if0.a_in  = '0; if0.ready_in  = 1'b1;
    rst_n16 = 1'b0;
    rst_n0  = 1'b0;
    step();
    step();
    check("rst_valid", 32'(if16.valid_out), 32'd0);
    check("rst_fixed", if16.fixed_out, 32'd0);
    check("rst_flags", 32'(flo(1'b0)), 32'd0);
    check("rst_valid0", 32'(if0.valid_out), 32'd0);
    rst_n16 = 1'b1;
    rst_n0  = 1'b1;
    step();

    // Directed vectors, FRAC_BITS=16
    run_one(1'b0, "one",    32'h3F800000, 32'h00010000, F_NONE);
    run_one(1'b0, "m2p5",   32'hC0200000, 32'hFFFD8000, F_NONE);
    run_one(1'b0, "p1p75",  32'h3FE00000, 32'h0001C000, F_NONE);
    run_one(1'b0, "m32768", 32'hC7000000, 32'h80000000, F_NONE);
    run_one(1'b0, "p32768", 32'h47000000, 32'h7FFFFFFF, F_OV);
    run_one(1'b0, "maxflt", 32'h7F7FFFFF, 32'h7FFFFFFF, F_OV);
    run_one(1'b0, "p2m16",  32'h37800000, 32'h00000001, F_NONE);
    run_one(1'b0, "p2m17",  32'h37000000, 32'h00000000, F_INX);
    run_one(1'b0, "denorm", 32'h00000001, 32'h00000000, F_INX);
    run_one(1'b0, "nan",    32'h7FC00000, 32'h00000000, F_INV);
    run_one(1'b0, "ninf",   32'hFF800000, 32'h80000000, F_OV);
    run_one(1'b0, "pinf",   32'h7F800000, 32'h7FFFFFFF, F_OV);
    run_one(1'b0, "nzero",  32'h80000000, 32'h00000000, F_NONE);
    step();

    // Streaming with a 3-cycle downstream stall
    idx = 0; got = 0; hold = 0; held = '0;
    for (int c = 0; c < 30; c++) begin
      if16.ready_in = !(c >= 6 && c < 9);
      if16.valid_in = (idx < 8);
      if16.a_in     = (idx < 8) ? svec[idx] : 32'd0;
      #1;
      check("s_ready", 32'(if16.ready_out), 32'(!(if16.valid_out && !if16.ready_in)));
      if (c == 6) check("s_stall_full", 32'(if16.valid_out), 32'd1);
      if (hold) begin
        check("s_hold_v", 32'(if16.valid_out), 32'd1);
        check("s_hold_d", if16.fixed_out, held);
      end
      acc = if16.valid_in && if16.ready_out;
      ret = if16.valid_out && if16.ready_in;
      if (ret) begin
        if (got < 8) check("s_data", if16.fixed_out, sexp[got]);
        got++;
      end
      hold = if16.valid_out && !if16.ready_in;
      held = if16.fixed_out;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    if16.valid_in = 1'b0;
    if16.ready_in = 1'b1;
    check("s_sent", 32'(idx), 32'd8);
    check("s_recv", 32'(got), 32'd8);
    check("s_drained", 32'(if16.valid_out), 32'd0);

    // FRAC_BITS=0
    run_one(1'b1, "f0_p2e31", 32'h4F000000, 32'h7FFFFFFF, F_OV);
    run_one(1'b1, "f0_m2e31", 32'hCF000000, 32'h80000000, F_NONE);
    run_one(1'b1, "f0_p1p5",  32'h3FC00000, 32'h00000001, F_INX);
    step();

    // Reset with two items in flight
    if0.ready_in = 1'b0;
    if0.a_in = 32'h3F800000; if0.valid_in = 1'b1;
    step();
    if0.a_in = 32'h40000000;
    step();
    if0.valid_in = 1'b0;
    step();
    check("r_pre_valid", 32'(if0.valid_out), 32'd1);
    check("r_pre_val",   if0.fixed_out, 32'd1);
    #2;
    rst_n0 = 1'b0;
    #1;
    check("r_async_valid", 32'(if0.valid_out), 32'd0);
    check("r_async_fixed", if0.fixed_out, 32'd0);
    step();
    step();
    rst_n0 = 1'b1;
    if0.ready_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("r_no_stale", 32'(if0.valid_out), 32'd0);
    end
    run_one(1'b1, "r_post", 32'h40400000, 32'h00000003, F_NONE);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
